jtcontra_snd_cen_irq: RTL and testbench

Timing and interrupt helper for the Contra sound subsystem. It produces fractional clock-enable strobes for the FM synthesizer from the 24 MHz system clock, at a programmable ratio n/m; the production setting is 105/704, about 3.58 MHz. It also holds the sound CPU's edge-latched IRQ request, which is set by the main CPU's sound-IRQ strobe and cleared by the sound CPU's acknowledge access.

---
 rtl/jtcontra_snd_cen_irq_if.sv | 13 +
 rtl/jtcontra_snd_cen_irq.sv | 67 ++++++
 tb/tb_jtcontra_snd_cen_irq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtcontra_snd_cen_irq_if.sv
// jtcontra_snd_cen_irq_if: ratio, strobe and IRQ signals of the Contra sound timing helper
interface jtcontra_snd_cen_irq_if;
  logic [9:0] n;
  logic [9:0] m;
  logic [1:0] cen;
  logic [1:0] cenb;
  logic       irq_sig;
  logic       irq_clr;
  logic       irq_set;
  logic       irq_n;
  modport master (output n, m, irq_sig, irq_clr, irq_set, input cen, cenb, irq_n);
  modport slave  (input n, m, irq_sig, irq_clr, irq_set, output cen, cenb, irq_n);
endinterface

// File: rtl/jtcontra_snd_cen_irq.sv
// jtcontra_snd_cen_irq: fractional n/m clock enables for the FM chip and edge-latched sound CPU IRQ
module jtcontra_snd_cen_irq (
  input logic                    clk,
  input logic                    rst,
  jtcontra_snd_cen_irq_if.slave  io_snd
);
  logic [10:0] r_cnt;
  logic        r_half;
  logic [1:0]  r_edgecnt;
  logic [1:0]  r_cen;
  logic [1:0]  r_cenb;
  logic        r_q;
  logic        r_last;
  logic [10:0] w_n;
  logic [10:0] w_m;
  logic [10:0] w_next;
  logic        w_over;
  logic        w_halfway;
  logic        w_insane;
  logic        w_tog0;
  assign w_n       = {1'b0, io_snd.n};
  assign w_m       = {1'b0, io_snd.m};
  assign w_next    = r_cnt + w_n;
  assign w_over    = w_next >= w_m;
  assign w_halfway = (w_next >= {2'b0, io_snd.m[9:1]}) && !r_half;
  assign w_insane  = r_cnt >= (w_m + w_n);
  // bit 0 of (edgecnt+1) & ~edgecnt: set on even edge counts, so cen[1] marks the odd-numbered cen[0]
  assign w_tog0    = ~r_edgecnt[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_half    <= 1'b0;
      r_edgecnt <= '0;
      r_cen     <= '0;
      r_cenb    <= '0;
    end else begin
      r_cen  <= '0;
      r_cenb <= '0;
      if (w_insane) begin
        r_cnt <= '0;
      end else begin
        if (w_halfway) begin
          r_cenb <= {w_tog0, 1'b1};
          r_half <= 1'b1;
        end
        if (w_over) begin
          r_cnt     <= w_next - w_m;
          r_half    <= 1'b0;
          r_edgecnt <= r_edgecnt + 2'd1;
          r_cen     <= {w_tog0, 1'b1};
        end else begin
          r_cnt <= w_next;
        end
      end
    end
  end
  // last tracks irq_sig even in reset so a level held high across reset is not an edge
  always_ff @(posedge clk) begin
    r_last <= io_snd.irq_sig;
    if (rst) r_q <= 1'b0;
    else if (io_snd.irq_clr) r_q <= 1'b0;
    else if (io_snd.irq_set || (io_snd.irq_sig && !r_last)) r_q <= 1'b1;
  end
  assign io_snd.cen   = r_cen;
  assign io_snd.cenb  = r_cenb;
  assign io_snd.irq_n = ~r_q;
endmodule

// File: tb/tb_jtcontra_snd_cen_irq.sv
// tb_jtcontra_snd_cen_irq: scoreboard bench with a cycle model plus directed rate and IRQ scenarios
module tb_jtcontra_snd_cen_irq;
  typedef struct packed {
    logic [1:0] cen;
    logic [1:0] cenb;
    logic       irq_n;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt = 0;
  int   m_edge = 0;
  bit   m_half = 0;
  bit   m_q = 0;
  bit   m_last = 0;
  exp_t sb[$];
  exp_t last_out;
  jtcontra_snd_cen_irq_if bus();
  jtcontra_snd_cen_irq dut (.clk(clk), .rst(rst), .io_snd(bus));
  always #5 clk = ~clk;

  // model the coming edge from the current inputs, then compare what the DUT registered
  task automatic tick(input string name);
    exp_t e;
    exp_t got;
    int   nx;
    int   nn;
    int   mm;
    nn = int'(bus.n);
    mm = int'(bus.m);
    e  = '0;
    if (rst) begin
      m_cnt = 0; m_half = 0; m_edge = 0; m_q = 0;
    end else begin
      nx = (m_cnt + nn) % 2048;
      if (m_cnt >= mm + nn) m_cnt = 0;
      else begin
        if (nx >= mm / 2 && !m_half) begin
          e.cenb = {m_edge % 2 == 0, 1'b1};
          m_half = 1;
        end
        if (nx >= mm) begin
          e.cen  = {m_edge % 2 == 0, 1'b1};
          m_cnt  = nx - mm;
          m_half = 0;
          m_edge = (m_edge + 1) % 4;
        end else m_cnt = nx;
      end
      if (bus.irq_clr) m_q = 0;
      else if (bus.irq_set || (bus.irq_sig && !m_last)) m_q = 1;
    end
    m_last  = bus.irq_sig;
    e.irq_n = !m_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got      = {bus.cen, bus.cenb, bus.irq_n};
    last_out = got;
    e        = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: cen=%b cenb=%b irq_n=%b, expected cen=%b cenb=%b irq_n=%b",
               name, got.cen, got.cenb, got.irq_n, e.cen, e.cenb, e.irq_n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick("reset_cycle");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.irq_sig = 0; bus.irq_clr = 0; bus.irq_set = 0;
    bus.n = 10'd1; bus.m = 10'd4;
    do_reset();
    n_cmp++;
    if (last_out !== 5'b0000_1) begin
      n_err++;
      $display("FAIL reset_state: got %b, expected 00001", last_out);
    end
  endtask

  task automatic test_ratio_1_4();
    logic [11:0] p_c0, p_c1, p_b0, p_b1;
    bus.n = 10'd1; bus.m = 10'd4;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick("ratio_1_4");
      p_c0[i] = last_out.cen[0];  p_c1[i] = last_out.cen[1];
      p_b0[i] = last_out.cenb[0]; p_b1[i] = last_out.cenb[1];
    end
    n_cmp += 4;
    if (p_c0 !== 12'b1000_1000_1000) begin n_err++; $display("FAIL ratio_cen0: got %b, expected 100010001000", p_c0); end
    if (p_c1 !== 12'b1000_0000_1000) begin n_err++; $display("FAIL ratio_cen1: got %b, expected 100000001000", p_c1); end
    if (p_b0 !== 12'b0010_0010_0010) begin n_err++; $display("FAIL ratio_cenb0: got %b, expected 001000100010", p_b0); end
    if (p_b1 !== 12'b0010_0000_0010) begin n_err++; $display("FAIL ratio_cenb1: got %b, expected 001000000010", p_b1); end
  endtask

  task automatic test_production();
    int c0 = 0, c1 = 0, b0 = 0, adj = 0;
    logic prev = 0;
    bus.n = 10'd105; bus.m = 10'd704;
    do_reset();
    for (int i = 0; i < 7040; i++) begin
      tick("production");
      c0 += last_out.cen[0]; c1 += last_out.cen[1]; b0 += last_out.cenb[0];
      if (prev && last_out.cen[0]) adj++;
      prev = last_out.cen[0];
    end
    n_cmp += 4;
    if (c0 != 1050) begin n_err++; $display("FAIL prod_cen0_count: got %0d, expected 1050", c0); end
    if (c1 != 525)  begin n_err++; $display("FAIL prod_cen1_count: got %0d, expected 525", c1); end
    if (b0 != 1050) begin n_err++; $display("FAIL prod_cenb0_count: got %0d, expected 1050", b0); end
    if (adj != 0)   begin n_err++; $display("FAIL prod_adjacent: got %0d, expected 0", adj); end
  endtask

  task automatic test_special_ratios();
    int seen = 0, full = 0;
    bus.n = 10'd0; bus.m = 10'd4;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick("n_zero");
      if (last_out.cen != 0 || last_out.cenb != 0) seen++;
    end
    bus.n = 10'd5; bus.m = 10'd5;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick("n_eq_m");
      full += last_out.cen[0];
    end
    n_cmp += 2;
    if (seen != 0) begin n_err++; $display("FAIL n_zero_strobes: got %0d, expected 0", seen); end
    if (full != 10) begin n_err++; $display("FAIL n_eq_m_cen0: got %0d, expected 10", full); end
  endtask

  task automatic test_sanity();
    bus.n = 10'd105; bus.m = 10'd704;
    do_reset();
    for (int i = 0; i < 10 && m_cnt <= 115; i++) tick("sanity_run");
    bus.m = 10'd10;
    tick("sanity_reset");
    n_cmp++;
    if (last_out.cen !== 2'b00 || last_out.cenb !== 2'b00) begin
      n_err++;
      $display("FAIL sanity_no_strobe: got cen=%b cenb=%b, expected 00 00", last_out.cen, last_out.cenb);
    end
    tick("sanity_resume");
    n_cmp++;
    if (last_out.cen[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sanity_resume: got cen0=%b, expected 1", last_out.cen[0]);
    end
    for (int i = 0; i < 10; i++) tick("sanity_after");
  endtask

  task automatic test_irq();
    bus.n = 10'd1; bus.m = 10'd4;
    bus.irq_sig = 0; bus.irq_clr = 0; bus.irq_set = 0;
    do_reset();
    bus.irq_sig = 1;
    tick("irq_rise");
    n_cmp++;
    if (last_out.irq_n !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b, expected 0", last_out.irq_n); end
    bus.irq_sig = 0;
    tick("irq_hold");
    tick("irq_hold");
    n_cmp++;
    if (last_out.irq_n !== 1'b0) begin n_err++; $display("FAIL irq_pending: got %b, expected 0", last_out.irq_n); end
    bus.irq_clr = 1;
    tick("irq_clear");
    bus.irq_clr = 0;
    n_cmp++;
    if (last_out.irq_n !== 1'b1) begin n_err++; $display("FAIL irq_clear: got %b, expected 1", last_out.irq_n); end
  endtask

  task automatic test_irq_priority();
    bus.irq_sig = 1; bus.irq_clr = 1;
    tick("prio_clr_edge");
    bus.irq_clr = 0;
    tick("prio_after");
    n_cmp++;
    if (last_out.irq_n !== 1'b1) begin n_err++; $display("FAIL prio_edge_lost: got %b, expected 1", last_out.irq_n); end
    bus.irq_sig = 0; bus.irq_set = 1;
    tick("prio_set");
    bus.irq_set = 0;
    n_cmp++;
    if (last_out.irq_n !== 1'b0) begin n_err++; $display("FAIL prio_set: got %b, expected 0", last_out.irq_n); end
    bus.irq_clr = 1; bus.irq_set = 1;
    tick("prio_clr_over_set");
    bus.irq_clr = 0; bus.irq_set = 0;
    n_cmp++;
    if (last_out.irq_n !== 1'b1) begin n_err++; $display("FAIL prio_clr_over_set: got %b, expected 1", last_out.irq_n); end
  endtask

  task automatic test_irq_reset_level();
    bus.irq_sig = 1;
    do_reset();
    tick("rst_level");
    tick("rst_level");
    n_cmp++;
    if (last_out.irq_n !== 1'b1) begin n_err++; $display("FAIL rst_level_no_irq: got %b, expected 1", last_out.irq_n); end
    bus.irq_sig = 0;
  endtask

  task automatic test_back_to_back();
    bus.n = 10'd105; bus.m = 10'd704;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) bus.n = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) == 0) bus.m = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) bus.n = 10'($urandom_range(1, 40));
      if ($urandom_range(0, 7) == 0) bus.m = 10'($urandom_range(1, 60));
      bus.irq_sig = ($urandom_range(0, 3) == 0) ? ~bus.irq_sig : bus.irq_sig;
      bus.irq_clr = $urandom_range(0, 9) == 0;
      bus.irq_set = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick("random");
    end
    rst = 0; bus.irq_clr = 0; bus.irq_set = 0;
  endtask

  initial begin
    test_reset();
    test_ratio_1_4();
    test_production();
    test_special_ratios();
    test_sanity();
    test_irq();
    test_irq_priority();
    test_irq_reset_level();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
